// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word, ALU opcode and arbiter FSM state.
// The opcode encoding must match the alu instance wired up by the parent.
package cpu_types_pkg;

    localparam int FLAGS_W = 3;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Round-robin successor: idx+1, wrapping n-1 back to 0.
    function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or above ptr_i,
// wrapping modulo NREQ, returned both one-hot and as an index.
module rr_picker #(
    parameter int NREQ  = 2,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);

    logic             found;
    logic [PTR_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = PTR_W'((32'(ptr_i) + i) % NREQ);
            if (!found && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                found         = 1'b1;
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational alu between NREQ requesters with a
// round-robin grant; operands and results are registered around the alu.
module alu_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int WORD_W = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*WORD_W-1:0] req_a,
    input  logic [NREQ*WORD_W-1:0] req_b,
    input  logic [NREQ*4-1:0]      req_op,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [WORD_W-1:0]      rsp_data,
    output logic [FLAGS_W-1:0]     rsp_flags,
    output logic [WORD_W-1:0]      alu_port_a,
    output logic [WORD_W-1:0]      alu_port_b,
    output logic [3:0]             alu_op,
    input  logic [WORD_W-1:0]      alu_out,
    input  logic [FLAGS_W-1:0]     alu_flags,
    output logic                   busy
);

    localparam int PTR_W = $clog2(NREQ);

    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [WORD_W-1:0]  op_a_q, op_a_d;
    logic [WORD_W-1:0]  op_b_q, op_b_d;
    aluop_t             op_q, op_d;
    logic [WORD_W-1:0]  rsp_data_q, rsp_data_d;
    logic [FLAGS_W-1:0] rsp_flags_q, rsp_flags_d;
    logic               armed_q;

    logic [NREQ-1:0]    grant;
    logic [PTR_W-1:0]   win_idx;
    logic               req_any;
    logic [WORD_W-1:0]  sel_a, sel_b;
    logic [3:0]         sel_op;

    rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx),
        .any_o   (req_any)
    );

    // One-hot AND-OR select of the winner's operands.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a  = req_a[i*WORD_W +: WORD_W];
                sel_b  = req_b[i*WORD_W +: WORD_W];
                sel_op = req_op[i*4 +: 4];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_d        = op_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        req_ready   = '0;
        rsp_valid   = '0;
        unique case (state_q)
            IDLE: begin
                // armed_q keeps req_ready low until the first edge after reset release.
                if (armed_q && req_any) begin
                    req_ready = grant;
                    op_a_d    = sel_a;
                    op_b_d    = sel_b;
                    op_d      = aluop_t'(sel_op);
                    owner_d   = win_idx;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_out;
                rsp_flags_d = alu_flags;
                state_d     = RESP;
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    rr_ptr_d = PTR_W'(rr_wrap_inc(32'(owner_q), NREQ));
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_q        <= aluop_t'(4'd0);
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_q        <= op_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            armed_q     <= 1'b1;
        end
    end

    assign alu_port_a = op_a_q;
    assign alu_port_b = op_b_q;
    assign alu_op     = op_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_flags  = rsp_flags_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a stub alu, directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_alu_arbiter;
    import cpu_types_pkg::*;

    localparam int NREQ = 2;
    localparam int W    = 32;

    logic                CLK = 1'b0;
    logic                nRST;
    logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*W-1:0]   req_a, req_b;
    logic [NREQ*4-1:0]   req_op;
    logic [W-1:0]        rsp_data, alu_port_a, alu_port_b, alu_out;
    logic [2:0]          rsp_flags, alu_flags;
    logic [3:0]          alu_op;
    logic                busy;

    int n_pass  = 0;
    int n_total = 0;

    alu_arbiter #(.NREQ(NREQ), .WORD_W(W)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_flags  (rsp_flags),
        .alu_port_a (alu_port_a),
        .alu_port_b (alu_port_b),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .alu_flags  (alu_flags),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    // Behavioural alu: returns {overflow, negative, zero, result}.
    function automatic logic [34:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        ov;
        r  = '0;
        ov = 1'b0;
        case (op)
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_ADD:  begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
            ALU_SUB:  begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = {31'b0, ($signed(a) < $signed(b))};
            ALU_SLTU: r = {31'b0, (a < b)};
            default:  r = '0;
        endcase
        return {ov, r[31], (r == 32'd0), r};
    endfunction

    always_comb {alu_flags, alu_out} = alu_fn(alu_op, alu_port_a, alu_port_b);

    function automatic logic [NREQ-1:0] oh(input int r);
        logic [NREQ-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[r*4 +: 4] = op;
        req_a[r*W +: W]  = a;
        req_b[r*W +: W]  = b;
    endtask

    task automatic reset_dut();
        req_valid = '0;
        rsp_ready = '0;
        nRST      = 1'b0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic consume(input int r);
        rsp_ready = oh(r);
        @(posedge CLK);
        #1 rsp_ready = '0;
    endtask

    // Single-requester op with full latency checks; other requester carries junk operands.
    task automatic do_op(input string nm, input int r, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ed, input logic [2:0] ef);
        for (int i = 0; i < NREQ; i++) set_req(i, 4'($urandom_range(0, 9)), $urandom, $urandom);
        set_req(r, op, a, b);
        req_valid = oh(r);
        #1 chk({nm, "_req_ready"}, 64'(req_ready), 64'(oh(r)));
        @(posedge CLK);
        #1 req_valid = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 4'($urandom_range(0, 9)), $urandom, $urandom);
        #1;
        chk({nm, "_exec_busy"}, 64'(busy), 64'd1);
        chk({nm, "_exec_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({nm, "_exec_alu_a"}, 64'(alu_port_a), 64'(a));
        chk({nm, "_exec_alu_op"}, 64'(alu_op), 64'(op));
        @(posedge CLK);
        #1;
        chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'(oh(r)));
        chk({nm, "_rsp_data"}, 64'(rsp_data), 64'(ed));
        chk({nm, "_rsp_flags"}, 64'(rsp_flags), 64'(ef));
        consume(r);
        chk({nm, "_done_busy"}, 64'(busy), 64'd0);
    endtask

    typedef struct {
        int          r;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic [2:0]  f;
    } vec_t;

    vec_t vecs[9];

    // Randomized-phase model state.
    logic        m_busy;
    int          m_phase;
    int          m_owner, m_ptr, m_win;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;
    logic [34:0] m_res;

    initial begin
        vecs[0] = '{0, ALU_ADD,  32'd5,          32'd7,          32'h0000_000C, 3'b000};
        vecs[1] = '{0, ALU_SUB,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF, 3'b100};
        vecs[2] = '{1, ALU_SUB,  32'd3,          32'd3,          32'h0000_0000, 3'b001};
        vecs[3] = '{1, ALU_ADD,  32'h7FFF_FFFF,  32'd1,          32'h8000_0000, 3'b110};
        vecs[4] = '{0, ALU_SUB,  32'd1,          32'd2,          32'hFFFF_FFFF, 3'b010};
        vecs[5] = '{1, ALU_XOR,  32'hFFFF_0000,  32'hFFFF_FFFF,  32'h0000_FFFF, 3'b000};
        vecs[6] = '{0, ALU_SLT,  32'hFFFF_FFFF,  32'd1,          32'h0000_0001, 3'b000};
        vecs[7] = '{1, ALU_SLTU, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 3'b001};
        vecs[8] = '{0, ALU_SLL,  32'd1,          32'd31,         32'h8000_0000, 3'b010};

        nRST      = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;

        // Reset state.
        #1 nRST = 1'b0;
        #3;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        reset_dut();

        // Directed vector table.
        for (int i = 0; i < 9; i++)
            do_op($sformatf("vec%0d", i), vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].f);

        // Strict alternation with both requesters always pending.
        reset_dut();
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            int e;
            e = k % 2;
            set_req(0, ALU_ADD, 32'(k * 16), 32'd1);
            set_req(1, ALU_ADD, 32'(k * 16 + 8), 32'd1);
            #1 chk($sformatf("alt%0d_req_ready", k), 64'(req_ready), 64'(oh(e)));
            @(posedge CLK);
            #1 chk($sformatf("alt%0d_exec_req_ready", k), 64'(req_ready), 64'd0);
            @(posedge CLK);
            #1;
            chk($sformatf("alt%0d_rsp_valid", k), 64'(rsp_valid), 64'(oh(e)));
            chk($sformatf("alt%0d_rsp_data", k), 64'(rsp_data), 64'(k * 16 + e * 8 + 1));
            consume(e);
        end
        req_valid = '0;

        // Held response with req1 waiting; then req1 wins on rr_ptr.
        set_req(0, ALU_SUB, 32'd3, 32'd3);
        req_valid = 2'b01;
        #1 chk("hold_accept", 64'(req_ready), 64'(2'b01));
        @(posedge CLK);
        #1;
        set_req(1, ALU_ADD, 32'd10, 32'd20);
        req_valid = 2'b10;
        #1 chk("hold_exec_req_ready", 64'(req_ready), 64'd0);
        @(posedge CLK);
        for (int k = 0; k < 5; k++) begin
            #2;
            chk($sformatf("hold%0d_rsp_valid", k), 64'(rsp_valid), 64'(2'b01));
            chk($sformatf("hold%0d_rsp_data", k), 64'(rsp_data), 64'd0);
            chk($sformatf("hold%0d_rsp_flags", k), 64'(rsp_flags), 64'(3'b001));
            chk($sformatf("hold%0d_req_ready", k), 64'(req_ready), 64'd0);
            @(posedge CLK);
        end
        #1 consume(0);
        req_valid = 2'b11;
        #1 chk("hold_next_req_ready", 64'(req_ready), 64'(2'b10));
        @(posedge CLK);
        #1 req_valid = '0;
        @(posedge CLK);
        #1;
        chk("hold_next_rsp_valid", 64'(rsp_valid), 64'(2'b10));
        chk("hold_next_rsp_data", 64'(rsp_data), 64'd30);
        consume(1);

        // Non-owner rsp_ready is ignored.
        set_req(0, ALU_OR, 32'h0000_00A5, 32'h0000_5A00);
        req_valid = 2'b01;
        @(posedge CLK);
        #1 req_valid = '0;
        @(posedge CLK);
        #1 rsp_ready = 2'b10;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("nonown%0d_rsp_valid", k), 64'(rsp_valid), 64'(2'b01));
            chk($sformatf("nonown%0d_busy", k), 64'(busy), 64'd1);
            @(posedge CLK);
            #1;
        end
        chk("nonown_rsp_data", 64'(rsp_data), 64'h5AA5);
        consume(0);
        chk("nonown_done_busy", 64'(busy), 64'd0);

        // Reset during EXEC, then pending req1 is served.
        set_req(0, ALU_ADD, 32'h1234, 32'd1);
        req_valid = 2'b01;
        @(posedge CLK);
        #1;
        set_req(1, ALU_SUB, 32'd50, 32'd8);
        req_valid = 2'b10;
        #1 nRST = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_alu_a", 64'(alu_port_a), 64'd0);
        chk("mid_rst_alu_op", 64'(alu_op), 64'd0);
        chk("mid_rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("mid_rst_rsp_flags", 64'(rsp_flags), 64'd0);
        @(posedge CLK);
        #1 nRST = 1'b1;
        #1 chk("post_rst_req_ready_early", 64'(req_ready), 64'd0);
        @(posedge CLK);
        #1 chk("post_rst_req_ready", 64'(req_ready), 64'(2'b10));
        @(posedge CLK);
        #1 req_valid = '0;
        @(posedge CLK);
        #1;
        chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(2'b10));
        chk("post_rst_rsp_data", 64'(rsp_data), 64'd42);
        consume(1);

        // Randomized traffic against the transaction-level model.
        reset_dut();
        m_busy  = 1'b0;
        m_phase = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_win   = 0;
        for (int c = 0; c < 400; c++) begin
            req_valid = NREQ'($urandom_range(0, 3));
            rsp_ready = NREQ'($urandom_range(0, 3));
            for (int i = 0; i < NREQ; i++) set_req(i, 4'($urandom_range(0, 9)), rnd_word(), rnd_word());
            #1;
            if (!m_busy) begin
                logic [NREQ-1:0] exp_rr;
                exp_rr = '0;
                m_win  = -1;
                for (int k = 0; k < NREQ; k++)
                    if (m_win < 0 && req_valid[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
                if (m_win >= 0) exp_rr = oh(m_win);
                chk("rnd_idle_req_ready", 64'(req_ready), 64'(exp_rr));
                chk("rnd_idle_rsp_valid", 64'(rsp_valid), 64'd0);
                chk("rnd_idle_busy", 64'(busy), 64'd0);
                if (m_win >= 0) begin
                    m_busy  = 1'b1;
                    m_phase = 1;
                    m_owner = m_win;
                    m_a     = req_a[m_win*W +: W];
                    m_b     = req_b[m_win*W +: W];
                    m_op    = req_op[m_win*4 +: 4];
                    m_res   = alu_fn(m_op, m_a, m_b);
                end
            end else if (m_phase == 1) begin
                chk("rnd_exec_req_ready", 64'(req_ready), 64'd0);
                chk("rnd_exec_rsp_valid", 64'(rsp_valid), 64'd0);
                chk("rnd_exec_alu_a", 64'(alu_port_a), 64'(m_a));
                chk("rnd_exec_alu_b", 64'(alu_port_b), 64'(m_b));
                chk("rnd_exec_alu_op", 64'(alu_op), 64'(m_op));
                m_phase = 2;
            end else begin
                chk("rnd_resp_req_ready", 64'(req_ready), 64'd0);
                chk("rnd_resp_rsp_valid", 64'(rsp_valid), 64'(oh(m_owner)));
                chk("rnd_resp_rsp_data", 64'(rsp_data), 64'(m_res[31:0]));
                chk("rnd_resp_rsp_flags", 64'(rsp_flags), 64'(m_res[34:32]));
                if (rsp_ready[m_owner]) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % NREQ;
                end
            end
            @(posedge CLK);
            #1;
        end
        req_valid = '0;
        rsp_ready = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
